// File: rtl/sirv_sram_icb_arb2.sv
// Two-master round-robin arbiter in front of the 1-cycle SRAM controller.
// Commands are tagged with the master ID in the top usr bit; responses are routed back by that tag.
module sirv_sram_icb_arb2 #(
  parameter int DW    = 64,
  parameter int MW    = 8,
  parameter int AW    = 16,
  parameter int USR_W = 2,
  parameter int OSTD  = 2
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               m0_cmd_valid,
  output logic               m0_cmd_ready,
  input  logic               m0_cmd_read,
  input  logic [AW-1:0]      m0_cmd_addr,
  input  logic [DW-1:0]      m0_cmd_wdata,
  input  logic [MW-1:0]      m0_cmd_wmask,
  input  logic [USR_W-1:0]   m0_cmd_usr,
  output logic               m0_rsp_valid,
  input  logic               m0_rsp_ready,
  output logic [DW-1:0]      m0_rsp_rdata,
  output logic [USR_W-1:0]   m0_rsp_usr,

  input  logic               m1_cmd_valid,
  output logic               m1_cmd_ready,
  input  logic               m1_cmd_read,
  input  logic [AW-1:0]      m1_cmd_addr,
  input  logic [DW-1:0]      m1_cmd_wdata,
  input  logic [MW-1:0]      m1_cmd_wmask,
  input  logic [USR_W-1:0]   m1_cmd_usr,
  output logic               m1_rsp_valid,
  input  logic               m1_rsp_ready,
  output logic [DW-1:0]      m1_rsp_rdata,
  output logic [USR_W-1:0]   m1_rsp_usr,

  output logic               uop_cmd_valid,
  input  logic               uop_cmd_ready,
  output logic               uop_cmd_read,
  output logic [AW-1:0]      uop_cmd_addr,
  output logic [DW-1:0]      uop_cmd_wdata,
  output logic [MW-1:0]      uop_cmd_wmask,
  output logic [USR_W:0]     uop_cmd_usr,
  input  logic               uop_rsp_valid,
  output logic               uop_rsp_ready,
  input  logic [DW-1:0]      uop_rsp_rdata,
  input  logic [USR_W:0]     uop_rsp_usr,

  output logic               arb_active
);

  localparam logic [1:0] OSTD_MAX = 2'(OSTD);

  logic       rr_ptr_r;
  logic [1:0] ostd_cnt_r;
  logic       hold_vld_r;
  logic       hold_id_r;

  logic       full_s;
  logic       gnt_id_s;
  logic       req_s;
  logic       cmd_hs_s;
  logic       rsp_hs_s;
  logic       rsp_id_s;
  logic [1:0] ostd_nxt_s;

  // Grant selection and command-channel mux; a stalled grant stays locked while its master holds valid.
  always_comb begin
    full_s   = (ostd_cnt_r == OSTD_MAX);
    gnt_id_s = rr_ptr_r;
    if (hold_vld_r && (hold_id_r ? m1_cmd_valid : m0_cmd_valid)) begin
      gnt_id_s = hold_id_r;
    end else if (m0_cmd_valid && !m1_cmd_valid) begin
      gnt_id_s = 1'b0;
    end else if (m1_cmd_valid && !m0_cmd_valid) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = rr_ptr_r;
    end
    req_s         = gnt_id_s ? m1_cmd_valid : m0_cmd_valid;
    uop_cmd_valid = req_s & ~full_s;
    m0_cmd_ready  = ~full_s & ~gnt_id_s & uop_cmd_ready;
    m1_cmd_ready  = ~full_s &  gnt_id_s & uop_cmd_ready;
    if (gnt_id_s) begin
      uop_cmd_read  = m1_cmd_read;
      uop_cmd_addr  = m1_cmd_addr;
      uop_cmd_wdata = m1_cmd_wdata;
      uop_cmd_wmask = m1_cmd_wmask;
      uop_cmd_usr   = {1'b1, m1_cmd_usr};
    end else begin
      uop_cmd_read  = m0_cmd_read;
      uop_cmd_addr  = m0_cmd_addr;
      uop_cmd_wdata = m0_cmd_wdata;
      uop_cmd_wmask = m0_cmd_wmask;
      uop_cmd_usr   = {1'b0, m0_cmd_usr};
    end
  end

  // Response routing by the ID tag carried in the top usr bit.
  always_comb begin
    rsp_id_s      = uop_rsp_usr[USR_W];
    m0_rsp_valid  = uop_rsp_valid & ~rsp_id_s;
    m1_rsp_valid  = uop_rsp_valid &  rsp_id_s;
    uop_rsp_ready = rsp_id_s ? m1_rsp_ready : m0_rsp_ready;
    m0_rsp_rdata  = uop_rsp_rdata;
    m1_rsp_rdata  = uop_rsp_rdata;
    m0_rsp_usr    = uop_rsp_usr[USR_W-1:0];
    m1_rsp_usr    = uop_rsp_usr[USR_W-1:0];
  end

  assign cmd_hs_s   = uop_cmd_valid & uop_cmd_ready;
  assign rsp_hs_s   = uop_rsp_valid & uop_rsp_ready;
  assign arb_active = m0_cmd_valid | m1_cmd_valid | (ostd_cnt_r != 2'd0);

  // Outstanding counter next value; a stray response at zero saturates instead of wrapping.
  always_comb begin
    ostd_nxt_s = ostd_cnt_r;
    case ({cmd_hs_s, rsp_hs_s})
      2'b10: ostd_nxt_s = ostd_cnt_r + 2'd1;
      2'b01: begin
        if (ostd_cnt_r != 2'd0) begin
          ostd_nxt_s = ostd_cnt_r - 2'd1;
        end else begin
          ostd_nxt_s = 2'd0;
        end
      end
      default: ostd_nxt_s = ostd_cnt_r;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r   <= 1'b0;
      ostd_cnt_r <= 2'd0;
      hold_vld_r <= 1'b0;
      hold_id_r  <= 1'b0;
    end else begin
      ostd_cnt_r <= ostd_nxt_s;
      hold_vld_r <= uop_cmd_valid & ~uop_cmd_ready;
      hold_id_r  <= gnt_id_s;
      if (cmd_hs_s) begin
        rr_ptr_r <= ~gnt_id_s;
      end
    end
  end

endmodule

// File: tb/tb_sirv_sram_icb_arb2.sv
// Directed self-checking bench for sirv_sram_icb_arb2 (default parameters, OSTD = 2).
module tb_sirv_sram_icb_arb2;
  localparam int DW = 64, MW = 8, AW = 16, USR_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m0_cmd_valid, m0_cmd_ready, m0_cmd_read, m0_rsp_valid, m0_rsp_ready;
  logic m1_cmd_valid, m1_cmd_ready, m1_cmd_read, m1_rsp_valid, m1_rsp_ready;
  logic [AW-1:0] m0_cmd_addr, m1_cmd_addr, uop_cmd_addr;
  logic [DW-1:0] m0_cmd_wdata, m1_cmd_wdata, uop_cmd_wdata, m0_rsp_rdata, m1_rsp_rdata, uop_rsp_rdata;
  logic [MW-1:0] m0_cmd_wmask, m1_cmd_wmask, uop_cmd_wmask;
  logic [USR_W-1:0] m0_cmd_usr, m1_cmd_usr, m0_rsp_usr, m1_rsp_usr;
  logic uop_cmd_valid, uop_cmd_ready, uop_cmd_read, uop_rsp_valid, uop_rsp_ready, arb_active;
  logic [USR_W:0] uop_cmd_usr, uop_rsp_usr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sirv_sram_icb_arb2 dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_read(m0_cmd_read),
    .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
    .m0_cmd_usr(m0_cmd_usr), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready),
    .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_usr(m0_rsp_usr),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_read(m1_cmd_read),
    .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
    .m1_cmd_usr(m1_cmd_usr), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready),
    .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_usr(m1_rsp_usr),
    .uop_cmd_valid(uop_cmd_valid), .uop_cmd_ready(uop_cmd_ready), .uop_cmd_read(uop_cmd_read),
    .uop_cmd_addr(uop_cmd_addr), .uop_cmd_wdata(uop_cmd_wdata), .uop_cmd_wmask(uop_cmd_wmask),
    .uop_cmd_usr(uop_cmd_usr), .uop_rsp_valid(uop_rsp_valid), .uop_rsp_ready(uop_rsp_ready),
    .uop_rsp_rdata(uop_rsp_rdata), .uop_rsp_usr(uop_rsp_usr), .arb_active(arb_active)
  );

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    m0_cmd_valid = 1'b0; m0_cmd_read = 1'b1; m0_cmd_addr = 16'h0100; m0_cmd_usr = 2'd0;
    m0_cmd_wdata = 64'h1111; m0_cmd_wmask = 8'h0F; m0_rsp_ready = 1'b0;
    m1_cmd_valid = 1'b0; m1_cmd_read = 1'b0; m1_cmd_addr = 16'h0200; m1_cmd_usr = 2'd2;
    m1_cmd_wdata = 64'h2222; m1_cmd_wmask = 8'hF0; m1_rsp_ready = 1'b0;
    uop_cmd_ready = 1'b0; uop_rsp_valid = 1'b0; uop_rsp_rdata = 64'h0; uop_rsp_usr = 3'b000;
  endtask

  // Advance to just after the next rising edge; inputs are driven here, outputs checked #1 later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    #3;
    chk_eq("rst_uop_cmd_valid", 64'(uop_cmd_valid), 64'd0);
    chk_eq("rst_m0_cmd_ready", 64'(m0_cmd_ready), 64'd0);
    chk_eq("rst_m1_cmd_ready", 64'(m1_cmd_ready), 64'd0);
    chk_eq("rst_m0_rsp_valid", 64'(m0_rsp_valid), 64'd0);
    chk_eq("rst_m1_rsp_valid", 64'(m1_rsp_valid), 64'd0);
    chk_eq("rst_uop_rsp_ready", 64'(uop_rsp_ready), 64'd0);
    chk_eq("rst_arb_active", 64'(arb_active), 64'd0);
    tick();
    rst_n = 1'b1;

    // Single master: four back-to-back reads, each answered one cycle later.
    for (int i = 0; i < 5; i++) begin
      tick();
      m0_cmd_valid  = (i < 4);
      m0_cmd_addr   = 16'(i * 8);
      m0_cmd_usr    = 2'd1;
      uop_cmd_ready = 1'b1;
      m0_rsp_ready  = 1'b1;
      uop_rsp_valid = (i > 0);
      uop_rsp_rdata = 64'hA000 + 64'(i);
      uop_rsp_usr   = 3'b001;
      #1;
      if (i < 4) begin
        chk_eq("s_cmd_valid", 64'(uop_cmd_valid), 64'd1);
        chk_eq("s_cmd_usr", 64'(uop_cmd_usr), 64'd1);
        chk_eq("s_cmd_addr", 64'(uop_cmd_addr), 64'(i * 8));
        chk_eq("s_m0_ready", 64'(m0_cmd_ready), 64'd1);
      end
      chk_eq("s_m0_rsp_valid", 64'(m0_rsp_valid), 64'(i > 0));
      chk_eq("s_m0_rdata", m0_rsp_rdata, 64'hA000 + 64'(i));
      chk_eq("s_m1_rsp_valid", 64'(m1_rsp_valid), 64'd0);
    end
    tick();
    idle();
    #1;
    chk_eq("s_idle_active", 64'(arb_active), 64'd0);

    // Contention: alternate m0,m1,... from reset, each response returned the next cycle.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      tick();
      m0_cmd_valid  = (i < 6);
      m1_cmd_valid  = (i < 6);
      uop_cmd_ready = 1'b1;
      m0_rsp_ready  = 1'b1;
      m1_rsp_ready  = 1'b1;
      uop_rsp_valid = (i > 0);
      uop_rsp_usr   = {1'((i - 1) % 2), 2'b00};
      #1;
      if (i < 6) begin
        chk_eq("c_m0_ready", 64'(m0_cmd_ready), 64'(i % 2 == 0));
        chk_eq("c_m1_ready", 64'(m1_cmd_ready), 64'(i % 2 == 1));
        chk_eq("c_cmd_id", 64'(uop_cmd_usr[2]), 64'(i % 2));
        chk_eq("c_cmd_addr", 64'(uop_cmd_addr), (i % 2 == 0) ? 64'h0100 : 64'h0200);
        chk_eq("c_cmd_wdata", uop_cmd_wdata, (i % 2 == 0) ? 64'h1111 : 64'h2222);
      end
      if (i > 0) chk_eq("c_rsp_ready", 64'(uop_rsp_ready), 64'd1);
    end

    // Backpressure: grant locked to m0 for three stalled cycles, then a handshake moves rr_ptr.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      m0_cmd_valid  = 1'b1;
      m1_cmd_valid  = 1'b1;
      uop_cmd_ready = (i == 3);
      #1;
      chk_eq("b_cmd_valid", 64'(uop_cmd_valid), 64'd1);
      chk_eq("b_cmd_id", 64'(uop_cmd_usr[2]), 64'd0);
      chk_eq("b_m0_ready", 64'(m0_cmd_ready), 64'(i == 3));
      chk_eq("b_m1_ready", 64'(m1_cmd_ready), 64'd0);
    end
    tick();
    m0_rsp_ready  = 1'b1;
    uop_rsp_valid = 1'b1;
    uop_rsp_usr   = 3'b000;
    #1;
    chk_eq("b_rr_to_m1", 64'(m1_cmd_ready), 64'd1);
    // Stall on lone m1 with rr_ptr back at 0; a late m0 request must not steal the grant.
    tick();
    uop_rsp_valid = 1'b0;
    m0_cmd_valid  = 1'b0;
    uop_cmd_ready = 1'b0;
    #1;
    chk_eq("l_solo_id", 64'(uop_cmd_usr[2]), 64'd1);
    tick();
    m0_cmd_valid = 1'b1;
    #1;
    chk_eq("l_hold_id", 64'(uop_cmd_usr[2]), 64'd1);
    tick();
    uop_cmd_ready = 1'b1;
    #1;
    chk_eq("l_hold_m1_ready", 64'(m1_cmd_ready), 64'd1);
    chk_eq("l_hold_m0_ready", 64'(m0_cmd_ready), 64'd0);

    // Outstanding limit: two handshakes fill the pipe; a response opens the path only next cycle.
    do_reset();
    tick();
    m0_cmd_valid  = 1'b1;
    uop_cmd_ready = 1'b1;
    #1;
    chk_eq("o_hs1", 64'(m0_cmd_ready), 64'd1);
    tick();
    #1;
    chk_eq("o_hs2", 64'(m0_cmd_ready), 64'd1);
    tick();
    m1_cmd_valid = 1'b1;
    #1;
    chk_eq("o_full_valid", 64'(uop_cmd_valid), 64'd0);
    chk_eq("o_full_m0_ready", 64'(m0_cmd_ready), 64'd0);
    chk_eq("o_full_m1_ready", 64'(m1_cmd_ready), 64'd0);
    chk_eq("o_full_active", 64'(arb_active), 64'd1);
    tick();
    uop_rsp_valid = 1'b1;
    uop_rsp_usr   = 3'b000;
    m0_rsp_ready  = 1'b1;
    #1;
    chk_eq("o_same_cyc_valid", 64'(uop_cmd_valid), 64'd0);
    chk_eq("o_rsp_ready", 64'(uop_rsp_ready), 64'd1);
    tick();
    uop_rsp_valid = 1'b0;
    #1;
    chk_eq("o_next_valid", 64'(uop_cmd_valid), 64'd1);
    chk_eq("o_next_m1_ready", 64'(m1_cmd_ready), 64'd1);

    // Response stall toward m1 while full; counter only drops when m1 accepts.
    for (int i = 0; i < 3; i++) begin
      tick();
      uop_rsp_valid = 1'b1;
      uop_rsp_usr   = 3'b110;
      uop_rsp_rdata = 64'hBEEF;
      m0_rsp_ready  = 1'b1;
      m1_rsp_ready  = (i == 2);
      #1;
      chk_eq("r_m1_valid", 64'(m1_rsp_valid), 64'd1);
      chk_eq("r_m0_valid", 64'(m0_rsp_valid), 64'd0);
      chk_eq("r_uop_ready", 64'(uop_rsp_ready), 64'(i == 2));
      chk_eq("r_m1_usr", 64'(m1_rsp_usr), 64'd2);
      chk_eq("r_m1_rdata", m1_rsp_rdata, 64'hBEEF);
      chk_eq("r_cmd_blocked", 64'(uop_cmd_valid), 64'd0);
    end
    tick();
    uop_rsp_valid = 1'b0;
    #1;
    chk_eq("r_reopen_m0_ready", 64'(m0_cmd_ready), 64'd1);

    // Async reset while full and a response is stalled.
    tick();
    uop_rsp_valid = 1'b1;
    uop_rsp_usr   = 3'b000;
    m0_rsp_ready  = 1'b0;
    #1;
    chk_eq("a_full_before", 64'(uop_cmd_valid), 64'd0);
    chk_eq("a_rsp_stall", 64'(uop_rsp_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk_eq("a_cnt_cleared", 64'(uop_cmd_valid), 64'd1);
    chk_eq("a_rr_cleared", 64'(m0_cmd_ready), 64'd1);
    m0_cmd_valid = 1'b0;
    m1_cmd_valid = 1'b0;
    #1;
    chk_eq("a_active_idle", 64'(arb_active), 64'd0);
    chk_eq("a_rsp_routed", 64'(m0_rsp_valid), 64'd1);
    rst_n = 1'b1;
    tick();
    m0_rsp_ready = 1'b1;
    #1;
    chk_eq("a_late_rsp_ready", 64'(uop_rsp_ready), 64'd1);
    tick();
    idle();
    #1;
    chk_eq("a_no_underflow", 64'(arb_active), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
